// File: rtl/mips_multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller and the datapath muxes it steers.
package mips_multicycle_controller_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } stateT;

    typedef enum logic [3:0] {
        CLS_ALU     = 4'd0,
        CLS_ADDI    = 4'd1,
        CLS_LW      = 4'd2,
        CLS_SW      = 4'd3,
        CLS_BEQ     = 4'd4,
        CLS_J       = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_JR      = 4'd7,
        CLS_ILLEGAL = 4'd8
    } instrClassT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    localparam logic [1:0] REG_SRC_PC  = 2'd0;
    localparam logic [1:0] REG_SRC_MEM = 2'd1;
    localparam logic [1:0] REG_SRC_ALU = 2'd2;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational classifier: op/func to instruction class, R-type ALU op and illegal flag.
module mips_instr_decode
    import mips_multicycle_controller_pkg::*;
(
    input  logic [5:0] opCode,
    input  logic [5:0] func,
    output instrClassT instrClass,
    output logic [1:0] rAluOp,
    output logic       illegal
);

    always_comb begin
        instrClass = CLS_ILLEGAL;
        rAluOp     = ALU_ADD;
        case (opCode)
            OP_RTYPE: begin
                case (func)
                    FN_ADD: begin instrClass = CLS_ALU; rAluOp = ALU_ADD; end
                    FN_SUB: begin instrClass = CLS_ALU; rAluOp = ALU_SUB; end
                    FN_AND: begin instrClass = CLS_ALU; rAluOp = ALU_AND; end
                    FN_OR:  begin instrClass = CLS_ALU; rAluOp = ALU_OR;  end
                    FN_JR:  instrClass = CLS_JR;
                    default: instrClass = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI: instrClass = CLS_ADDI;
            OP_LW:   instrClass = CLS_LW;
            OP_SW:   instrClass = CLS_SW;
            OP_BEQ:  instrClass = CLS_BEQ;
            OP_J:    instrClass = CLS_J;
            OP_JAL:  instrClass = CLS_JAL;
            default: instrClass = CLS_ILLEGAL;
        endcase
        illegal = (instrClass == CLS_ILLEGAL);
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with memReady stalls and sticky trap.
module mips_multicycle_controller
    import mips_multicycle_controller_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opCode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             memReady,
    output logic             irWrite,
    output logic             pcWrite,
    output logic [1:0]       pcSrc,
    output logic [1:0]       regDst,
    output logic [1:0]       regSrc,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             regWrite,
    output logic             memRead,
    output logic             memWrite,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    stateT      state;
    logic [5:0] opReg;
    logic [5:0] funcReg;
    logic [5:0] decOp;
    logic [5:0] decFunc;
    instrClassT cls;
    logic [1:0] rAluOp;
    logic       illegal;

    // Decode live inputs while in DECODE, the latched instruction afterwards.
    assign decOp   = (state == DECODE) ? opCode : opReg;
    assign decFunc = (state == DECODE) ? func   : funcReg;

    mips_instr_decode uDecode (
        .opCode     (decOp),
        .func       (decFunc),
        .instrClass (cls),
        .rAluOp     (rAluOp),
        .illegal    (illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            opReg   <= '0;
            funcReg <= '0;
            retired <= '0;
        end else begin
            if (pcWrite) retired <= retired + 1'b1;
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    opReg   <= opCode;
                    funcReg <= func;
                    state   <= illegal ? TRAP : EXEC;
                end
                EXEC: begin
                    case (cls)
                        CLS_ALU, CLS_ADDI: state <= WB;
                        CLS_LW, CLS_SW:    state <= MEM;
                        default:           state <= FETCH;
                    endcase
                end
                MEM: begin
                    if (memReady) state <= (cls == CLS_LW) ? WB : FETCH;
                end
                WB:      state <= FETCH;
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    assign trap = (state == TRAP);

    always_comb begin
        irWrite  = 1'b0;
        pcWrite  = 1'b0;
        pcSrc    = PC_SRC_PC4;
        regDst   = REG_DST_RT;
        regSrc   = REG_SRC_PC;
        ALUSrc   = 1'b0;
        ALUOp    = ALU_ADD;
        regWrite = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        case (state)
            FETCH: irWrite = 1'b1;
            EXEC: begin
                case (cls)
                    CLS_ALU: ALUOp = rAluOp;
                    CLS_ADDI, CLS_LW, CLS_SW: ALUSrc = 1'b1;
                    CLS_BEQ: begin
                        ALUOp   = ALU_SUB;
                        pcWrite = 1'b1;
                        pcSrc   = zero ? PC_SRC_BRANCH : PC_SRC_PC4;
                    end
                    CLS_J: begin
                        pcWrite = 1'b1;
                        pcSrc   = PC_SRC_JUMP;
                    end
                    CLS_JAL: begin
                        pcWrite  = 1'b1;
                        pcSrc    = PC_SRC_JUMP;
                        regWrite = 1'b1;
                        regDst   = REG_DST_R31;
                        regSrc   = REG_SRC_PC;
                    end
                    CLS_JR: begin
                        pcWrite = 1'b1;
                        pcSrc   = PC_SRC_RS;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                ALUSrc   = 1'b1;
                memRead  = (cls == CLS_LW);
                memWrite = (cls == CLS_SW);
                pcWrite  = memReady && (cls == CLS_SW);
            end
            WB: begin
                // ALU controls stay as in EXEC/MEM so the written result stays stable.
                regWrite = 1'b1;
                pcWrite  = 1'b1;
                case (cls)
                    CLS_ALU: begin
                        regDst = REG_DST_RD;
                        regSrc = REG_SRC_ALU;
                        ALUOp  = rAluOp;
                    end
                    CLS_ADDI: begin
                        regSrc = REG_SRC_ALU;
                        ALUSrc = 1'b1;
                    end
                    CLS_LW: begin
                        regSrc = REG_SRC_MEM;
                        ALUSrc = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (!rst_n) begin
            irWrite  = 1'b0;
            pcWrite  = 1'b0;
            regWrite = 1'b0;
            memRead  = 1'b0;
            memWrite = 1'b0;
        end
    end

endmodule
